// File: rtl/ad_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_capture_pkg
// Description : Shared types and default constants for the ADC capture
//               sequencer and its stereo-frame FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_capture_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_SETTLE_FRAMES = 4;
  localparam int DEF_CNT_W         = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  // One stereo frame as stored in the FIFO (left word in the upper half)
  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } frame_t;

endpackage
`default_nettype wire

// File: rtl/ad_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ad_pair_fifo
// Description : Synchronous show-ahead FIFO for stereo frames. A push while
//               full is accepted only when a pop happens in the same cycle.
//               The read port reads zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_pair_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Occupancy comes from the extra pointer bit, so full and empty are distinct
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign empty   = (fill == '0);
  assign full    = (fill == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the read port is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/ad_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad_capture_ctrl
// Description : Start/settle/capture/flush sequencer that pairs LRCK-edge
//               words into left/right frames and streams them out of a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_capture_ctrl
  import ad_capture_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   fpga_gclk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       frame_count,
  input  logic [DATA_W-1:0]      sample_data,
  input  logic                   pos_edge,
  input  logic                   neg_edge,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_left,
  output logic [DATA_W-1:0]      m_right,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int               SW       = $clog2(SETTLE_FRAMES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                pos_dly_q, neg_dly_q;
  logic [DATA_W-1:0]   left_q, left_d;
  logic                have_left_q, have_left_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    fc_q, fc_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic                ovf_q, ovf_d;

  logic                start_ok;
  logic                frame_push;
  logic                pop;
  logic                last_frame;
  logic                settle_hit;
  logic [CNT_W-1:0]    cnt_inc;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] head;

  assign start_ok   = (state_q == IDLE) && start && !stop;
  assign pop        = m_valid && m_ready;
  // Word is on sample_data in the cycle after the edge pulse
  assign frame_push = (state_q == CAPTURE) && pos_dly_q && have_left_q;
  // Saturating increment so continuous mode can never wrap into a match
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign last_frame = frame_push && (fc_q != '0) && (cnt_inc == fc_q);
  assign settle_hit = (state_q == SETTLE) && pos_dly_q &&
                      (settle_q + SW'(1) == SW'(SETTLE_FRAMES));

  // State and done registers
  always_ff @(posedge fpga_gclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (SETTLE_FRAMES == 0) ? CAPTURE : SETTLE;
      SETTLE:  if (stop) state_d = FLUSH;
               else if (settle_hit) state_d = CAPTURE;
      CAPTURE: if (stop || last_frame) state_d = FLUSH;
      FLUSH:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs; done registers so it coincides with busy falling
  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == FLUSH) && fifo_empty;
    done   = done_q;
  end

  // Datapath next values: run setup, settle count, left hold, frame count, overflow
  always_comb begin
    left_d      = left_q;
    have_left_d = have_left_q;
    cnt_d       = cnt_q;
    fc_d        = fc_q;
    settle_d    = settle_q;
    ovf_d       = ovf_q;
    if (start_ok) begin
      ovf_d       = 1'b0;
      cnt_d       = '0;
      fc_d        = frame_count;
      settle_d    = '0;
      have_left_d = 1'b0;
    end
    if ((state_q == SETTLE) && pos_dly_q) settle_d = settle_q + SW'(1);
    if (state_q == CAPTURE) begin
      if (neg_dly_q) begin
        left_d      = sample_data;
        have_left_d = 1'b1;
      end
      // A right word either completes the frame or is dropped for alignment
      if (pos_dly_q) have_left_d = 1'b0;
      if (frame_push) begin
        cnt_d = cnt_inc;
        if (fifo_full && !pop) ovf_d = 1'b1;
      end
      if (stop) have_left_d = 1'b0;
    end
  end

  // Datapath registers including the edge-delay stage
  always_ff @(posedge fpga_gclk or posedge reset) begin
    if (reset) begin
      pos_dly_q   <= 1'b0;
      neg_dly_q   <= 1'b0;
      left_q      <= '0;
      have_left_q <= 1'b0;
      cnt_q       <= '0;
      fc_q        <= '0;
      settle_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pos_dly_q   <= pos_edge;
      neg_dly_q   <= neg_edge;
      left_q      <= left_d;
      have_left_q <= have_left_d;
      cnt_q       <= cnt_d;
      fc_q        <= fc_d;
      settle_q    <= settle_d;
      ovf_q       <= ovf_d;
    end
  end

  ad_pair_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (fpga_gclk),
    .rst     (reset),
    .push    (frame_push),
    .wr_data ({left_q, sample_data}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill)
  );

  assign m_valid  = !fifo_empty;
  assign m_left   = head[2*DATA_W-1:DATA_W];
  assign m_right  = head[DATA_W-1:0];
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/ad_capture_ctrl.md
# ad_capture_ctrl

Capture sequencer placed after the ADC serial-to-parallel driver in the `fpga_gclk` domain. It runs a start/settle/capture/flush sequence and pairs the driver's per-edge 32-bit words into left/right stereo frames. Frames are buffered in a small FIFO and presented on a valid/ready stream to the downstream DSP or storage logic. It also counts frames, discards ADC settling frames and flags overflow.

## Interface
- `DATA_W`, 32: width of one channel word.
- `DEPTH`, 16: FIFO depth in stereo frames; must be a power of 2.
- `SETTLE_FRAMES`, 4: number of complete LRCK periods discarded after start.
- `CNT_W`, 16: width of the frame counter.

- `fpga_gclk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a capture run.
- `stop`  in  1  one-cycle pulse that ends the run early.
- `frame_count`  in  CNT_W  frames to capture; 0 means continuous until `stop`. Sampled on an accepted `start`.
- `sample_data`  in  DATA_W  parallel word from the driver. Valid in the cycle after a `pos_edge` or `neg_edge` pulse.
- `pos_edge`  in  1  registered LRCK rising-edge pulse from the driver.
- `neg_edge`  in  1  registered LRCK falling-edge pulse from the driver.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  downstream accepts the head frame.
- `m_left`  out  DATA_W  head-frame left word.
- `m_right`  out  DATA_W  head-frame right word.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the run completes.
- `overflow`  out  1  sticky; a frame was dropped because the FIFO was full.
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Channel mapping.** A `neg_edge` closes the LRCK-high half, so that word is LEFT. A `pos_edge` closes the LRCK-low half, so that word is RIGHT. A frame is complete at the `pos_edge` that follows a captured left word.
- **Word capture.** The edge pulse is delayed one cycle. `sample_data` is captured in that delayed cycle.
- **State IDLE.** Outputs quiet.
  - `start` moves to SETTLE.
  - On entry to SETTLE: clear `overflow`, clear the frame counter, latch `frame_count`.
  - `start` while `busy` is ignored.
  - If `start` and `stop` arrive in the same cycle, `stop` wins and the state stays IDLE.
- **State SETTLE.** Count `pos_edge` pulses.
  - After SETTLE_FRAMES of them, move to CAPTURE.
  - SETTLE_FRAMES = 0 enters CAPTURE in the cycle after `start`.
- **State CAPTURE.**
  - `neg_edge`: latch the left word and set `have_left`.
  - `pos_edge` with `have_left` set: push {left, right}, clear `have_left`, increment the counter.
  - `pos_edge` with `have_left` clear: discard the word. This aligns the first frame.
  - When the counter reaches a nonzero `frame_count`, move to FLUSH in the cycle after the final push.
  - `stop` moves to FLUSH immediately; a half-captured left word is discarded.
- **State FLUSH.** Wait for the FIFO to empty (`fill` = 0). Then pulse `done` for one cycle and return to IDLE.
- **`stop` in SETTLE.** Go to FLUSH; with an empty FIFO this gives `done` one cycle later.
- **Push while full.** If the FIFO is full and there is no same-cycle pop, the frame is dropped, `overflow` is set and the counter still increments. A push at full with `m_valid & m_ready` in the same cycle is accepted.
- **Pop.** `m_valid & m_ready` pops the head. `m_left` and `m_right` hold the head frame (show-ahead) and are stable while `m_valid` is high and `m_ready` is low.
- **Counter width.** The counter saturates at 2^CNT_W−1 in continuous mode and never wraps to a match.

## Timing
- Reset values: state IDLE; `busy`, `done`, `overflow`, `m_valid` all 0; `fill` 0; `m_left`/`m_right` 0; `have_left` 0; FIFO pointers 0.
- If `pos_edge` is high in cycle T, the word is captured and pushed at the end of T+1. `m_valid` rises in T+2 if the FIFO was empty.
- `busy` rises in the cycle after `start`.
- `done` is high for exactly one cycle. `busy` falls in the same cycle as `done`.
- `fill` updates in the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- Reset mid-run: immediate return to IDLE and FIFO emptied; no `done`.

## Structure
- **Package `ad_capture_pkg`:**
  - state enum: IDLE, SETTLE, CAPTURE, FLUSH;
  - default parameter constants;
  - frame struct {left, right}.
- **Sub-module `ad_pair_fifo`:**
  - synchronous FIFO of width 2×DATA_W and depth DEPTH;
  - show-ahead output, `full`, `empty` and `fill` outputs;
  - push-at-full allowed when a pop happens in the same cycle.
- The top level holds the FSM, the edge-delay register, the left-word holding register, the counters and the overflow flag.

## Test plan
- **Basic run.** SETTLE_FRAMES=4, `frame_count`=3, `m_ready`=1, alternating edges with words L=0x11.., R=0x22.. per frame → the first 4 frames are discarded; exactly 3 frames appear with the correct L/R order; one `done` pulse; `busy` low afterwards.
- **Alignment.** The first CAPTURE edge is a `pos_edge` → that word is discarded; the first output frame is the following neg/pos pair.
- **Overflow.** `m_ready`=0 for 17 frames with DEPTH=16 → `fill`=16 and `overflow`=1 after frame 17. Then `m_ready`=1 → frames 1–16 drain in order; `overflow` stays set until the next `start`.
- **Early stop.** `stop` issued mid-frame after 2 full frames in continuous mode → 2 frames output; the pending left word is dropped; `done` follows once the FIFO is empty.
- **Start/stop collision.** `start`+`stop` in the same cycle in IDLE → the state stays IDLE. Then `start` while `busy` → ignored and `frame_count` is not re-latched.
- **Reset mid-capture.** Assert `reset` with `fill`=5 → all outputs return to their reset values; no `done`; a new `start` after reset runs normally.
